// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: a 4-entry byte FIFO feeds an FSM that
// serializes each byte as an 11-bit PS/2 frame. The FSM generates both
// ps2_clk and ps2_data, with data changing only on the rising clock edge.
module ps2_kbd_tx #(
    parameter int CLK_DIV  = 50,  // system clocks per PS/2 half-period (>= 2)
    parameter int GAP_HALF = 4    // idle half-periods after each stop bit
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_CYC = GAP_HALF * CLK_DIV;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    // FIFO storage and bookkeeping
    logic [3:0][7:0] mem_q, mem_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;

    // Serializer state
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   half_q, half_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [9:0]      shift_q, shift_d;   // {stop, parity, data}; bit 0 goes out next
    logic            ps2_clk_q, ps2_clk_d;
    logic            ps2_data_q, ps2_data_d;

    logic            push;
    logic            pop;
    logic [7:0]      head;

    assign in_ready = (count_q != 3'd4);
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign busy     = (state_q != S_IDLE) || (count_q != 3'd0);

    // Frame sequencer: IDLE -> (HIGH/LOW) x 11 bits -> GAP -> IDLE
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        gap_d      = gap_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (count_q != 3'd0) begin
                    pop        = 1'b1;
                    shift_d    = {1'b1, ~^head, head};
                    bit_idx_d  = 4'd0;
                    ps2_data_d = 1'b0;          // start bit
                    half_d     = '0;
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                if (half_q == HALF_LAST) begin
                    half_d    = '0;
                    ps2_clk_d = 1'b0;
                    state_d   = S_LOW;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_LOW: begin
                if (half_q == HALF_LAST) begin
                    half_d    = '0;
                    ps2_clk_d = 1'b1;
                    if (bit_idx_q < 4'd10) begin
                        // next bit is launched on the rising edge only
                        bit_idx_d  = bit_idx_q + 4'd1;
                        ps2_data_d = shift_q[0];
                        shift_d    = {1'b0, shift_q[9:1]};
                        state_d    = S_HIGH;
                    end else begin
                        ps2_data_d = 1'b1;
                        gap_d      = '0;
                        state_d    = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO next-state: push on accept, pop when the sequencer starts a frame
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops any partial frame and queued bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            half_q     <= '0;
            gap_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            half_q     <= half_d;
            gap_q      <= gap_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a behavioural PS/2 receiver decodes frames on the
// falling edge of ps2_clk and is compared against the queue of bytes the
// bench expects to be sent, plus frame timing derived from the bit-period math.
module tb_ps2_kbd_tx;

    localparam int CD   = 4;
    localparam int GH   = 4;
    localparam int FRM  = (22 + GH) * CD + 1;   // start-to-start spacing

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, ps2_clk, ps2_data, busy;

    ps2_kbd_tx #(.CLK_DIV(CD), .GAP_HALF(GH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // ---------------- behavioural receiver / line monitor ----------------
    logic        pc = 1'b1, pd = 1'b1;
    int          nbits = 0, last_chg = 0, fall_c = 0, nfalls = 0;
    logic [10:0] fb, last_fb;
    int          falls[$];
    int          frame_first[$];
    logic [7:0]  rx_q[$];
    int          mon_err = 0, stab_err = 0, width_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0; pc = 1'b1; pd = 1'b1;
        end else begin
            if (ps2_data !== pd) begin
                if (!pc && !ps2_clk) stab_err++;
                last_chg = cyc;
            end
            if (pc && !ps2_clk) begin
                nfalls++;
                falls.push_back(cyc);
                if (cyc - last_chg < CD) stab_err++;
                if (nbits == 0) frame_first.push_back(cyc);
                fb[nbits] = ps2_data;
                nbits++;
                fall_c = cyc;
                if (nbits == 11) begin
                    nbits = 0;
                    last_fb = fb;
                    if (fb[0] !== 1'b0 || fb[10] !== 1'b1 || (^fb[9:1]) !== 1'b1) mon_err++;
                    rx_q.push_back(fb[8:1]);
                end
            end
            if (!pc && ps2_clk && (cyc - fall_c != CD)) width_err++;
            pc = ps2_clk;
            pd = ps2_data;
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] bs[6];
    logic       rdy[6];
    logic [7:0] exp_q[$];
    int         first_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present bs[0..n-1] on consecutive cycles; rdy[] holds pre-edge in_ready
    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first_edge = cyc + 1;
            in_data  = bs[i];
            in_valid = 1'b1;
            rdy[i]   = in_ready;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int end_cyc);
        end_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin end_cyc = cyc; break; end
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete(); exp_q.delete(); falls.delete(); frame_first.delete();
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    int ec, n, n0;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_clk", {31'd0, ps2_clk}, 32'd1);
        chk("rst_data", {31'd0, ps2_data}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single byte 0x1C: exact timing of every fall and the end of busy
        bs[0] = 8'h1C;
        push_seq(1);
        exp_q.push_back(8'h1C);
        @(negedge clk);
        chk("start_data", {31'd0, ps2_data}, 32'd0);
        chk("start_clk", {31'd0, ps2_clk}, 32'd1);
        wait_idle(ec);
        chk("single_nfalls", falls.size(), 32'd11);
        for (int k = 1; k <= 11 && k <= falls.size(); k++)
            chk("fall_time", falls[k-1], first_edge + 1 + (2*k - 1) * CD);
        chk("busy_fall", ec, first_edge + 1 + (22 + GH) * CD);
        chk("frame_1c", {21'd0, last_fb}, {21'd0, model_frame(8'h1C)});
        chk("frame_1c_lit", {21'd0, last_fb}, 32'b100_0011_1000);
        cmp_rx("single");

        // parity corner values
        bs[0] = 8'h00; bs[1] = 8'hFF; bs[2] = 8'hF0;
        for (int j = 0; j < 3; j++) begin
            bs[0] = (j == 0) ? 8'h00 : (j == 1) ? 8'hFF : 8'hF0;
            push_seq(1);
            exp_q.push_back(bs[0]);
            wait_idle(ec);
            chk("parity_bit", {31'd0, last_fb[9]}, 32'd1);
            cmp_rx("parity");
        end

        // back-to-back make/break
        bs[0] = 8'hF0; bs[1] = 8'h1C;
        push_seq(2);
        chk("b2b_rdy0", {31'd0, rdy[0]}, 32'd1);
        chk("b2b_rdy1", {31'd0, rdy[1]}, 32'd1);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h1C);
        wait_idle(ec);
        chk("b2b_frames", frame_first.size(), 32'd2);
        if (frame_first.size() >= 2)
            chk("b2b_spacing", frame_first[1] - frame_first[0], FRM);
        cmp_rx("b2b");

        // full FIFO: six pushes, the sixth is refused
        for (int i = 0; i < 6; i++) bs[i] = 8'($urandom);
        push_seq(6);
        for (int i = 0; i < 6; i++) begin
            chk("full_rdy", {31'd0, rdy[i]}, (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) exp_q.push_back(bs[i]);
        end
        wait_idle(ec);
        cmp_rx("full");

        // randomized bursts of up to 4 bytes from idle always fit
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) bs[i] = 8'($urandom);
            push_seq(n);
            for (int i = 0; i < n; i++) begin
                chk("rand_rdy", {31'd0, rdy[i]}, 32'd1);
                exp_q.push_back(bs[i]);
            end
            wait_idle(ec);
            for (int i = 1; i < frame_first.size(); i++)
                chk("rand_spacing", frame_first[i] - frame_first[i-1], FRM);
            cmp_rx("rand");
        end

        // asynchronous reset during data bit 3 with two bytes queued
        bs[0] = 8'h1C; bs[1] = 8'hAA; bs[2] = 8'h55;
        push_seq(3);
        for (int i = 0; i < 3000 && nbits < 5; i++) @(negedge clk);
        chk("mid_reach_bit3", {31'd0, (nbits >= 5)}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_clk", {31'd0, ps2_clk}, 32'd1);
        chk("arst_data", {31'd0, ps2_data}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        rx_q.delete(); exp_q.delete(); falls.delete(); frame_first.delete();
        n0 = nfalls;
        repeat (300) @(negedge clk);
        chk("post_rst_quiet", nfalls - n0, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        bs[0] = 8'($urandom);
        push_seq(1);
        exp_q.push_back(bs[0]);
        wait_idle(ec);
        cmp_rx("recover");

        // line discipline over every frame
        chk("frame_format", mon_err, 32'd0);
        chk("hold_stability", stab_err, 32'd0);
        chk("low_width", width_err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
